round_arb: RTL
==============

ROUND_ARB -- requirements
Module: round_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesters sharing the rounder (2..16).
REQ-002 SHALL have parameter IN_W, default 18, the signed input sample width.
REQ-003 SHALL have parameter OUT_W, default 16, the signed output sample width (OUT_W < IN_W).
REQ-004 SHALL have port mclk  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port i_init_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port i_req_vld  input  N_REQ  per-requester sample valid.
REQ-007 SHALL have port i_req_data  input  N_REQ*IN_W  samples, requester k in bits [k*IN_W +: IN_W].
REQ-008 SHALL have port o_req_rdy  output  N_REQ  per-requester accept; at most one bit high.
REQ-009 SHALL have port i_rdy  input  1  downstream ready.
REQ-010 SHALL have port o_vld  output  1  rounded sample valid.
REQ-011 SHALL have port o_data  output  OUT_W  rounded sample.
REQ-012 SHALL have port o_id  output  max(1,$clog2(N_REQ))  index of the requester that sourced o_data.

Function
REQ-013 SHALL transfer a sample from requester k in a cycle where i_req_vld[k] and o_req_rdy[k] are both high.
REQ-014 SHALL grant round-robin: among requesters with i_req_vld high, pick the lowest index >= ptr, wrapping to index 0.
REQ-015 SHALL set ptr to (granted index + 1) mod N_REQ after each transfer; ptr SHALL hold when there is no transfer.
REQ-016 SHALL drive o_req_rdy combinationally from i_req_vld, ptr and the stall signal; o_req_rdy SHALL never depend on i_req_data.
REQ-017 SHALL use a two-stage pipeline: stage 1 registers the granted sample and index; stage 2 registers the rounded result into o_data/o_id.
REQ-018 SHALL have latency 2: a sample transferred in cycle t appears with o_vld high in cycle t+2 when i_rdy is high.
REQ-019 SHALL stall when o_vld=1 and i_rdy=0: both stages hold and all o_req_rdy bits are low.
REQ-020 SHALL sustain one transfer per cycle with no bubbles while i_rdy=1.
REQ-021 SHALL hold o_data and o_id stable while o_vld=1 and i_rdy=0.
REQ-022 SHALL round convergently (round-half-to-even), dropping the IN_W-OUT_W LSBs: add 0 followed by (IN_W-OUT_W-1) ones, plus the kept LSB, then truncate.
REQ-023 SHALL never output a sample twice and SHALL never drop an accepted sample.
REQ-024 SHALL keep o_req_rdy all low when no requester is valid.

Reset
REQ-025 SHALL, while i_init_n=0 at a rising edge, clear ptr, both stage valids and o_vld to 0, and set o_data and o_id to 0.
REQ-026 SHALL drive o_req_rdy all low while i_init_n=0.
REQ-027 SHALL discard in-flight samples if reset is asserted mid-stream; the first grant after release SHALL go to the lowest-index valid requester.

Configuration
REQ-028 SHALL support macro ROUND_ARB_SAT_EN: when defined, a round-up that overflows OUT_W SHALL saturate to +2^(OUT_W-1)-1; when undefined, the result SHALL wrap (two's complement).

Verification
REQ-029 SHALL cover: all 4 requesters valid continuously, i_rdy=1 -> grants 0,1,2,3,0,... one per cycle, o_id follows the same order two cycles later.
REQ-030 SHALL cover: IN_W=18, OUT_W=16, inputs 6, 10, -6, 5 -> o_data 2, 2, -2, 1.
REQ-031 SHALL cover: input 131071 -> o_data -32768 without ROUND_ARB_SAT_EN and 32767 with it.
REQ-032 SHALL cover: i_rdy low for 5 cycles with o_vld high -> o_data/o_id frozen, o_req_rdy all 0, no loss or duplication after i_rdy rises.
REQ-033 SHALL cover: only requesters 1 and 3 valid with ptr=2 -> 3 granted first, then 1.
REQ-034 SHALL cover: i_init_n pulsed low for 1 cycle with 2 samples in flight -> o_vld=0 the next cycle, in-flight samples never appear, grant restarts at index 0.

Source files
------------

// File: rtl/round_arb.sv
// ---------------------------------------------------------------------------
// round_arb
//
// Purpose:
//   Shares one convergent (round-half-to-even) rounder between N_REQ
//   requesters. A round-robin arbiter picks one valid requester per cycle.
//   The granted sample then passes through a two-stage pipeline:
//     stage 1 - registers the granted sample and its requester index
//     stage 2 - registers the rounded sample into o_data / o_id
//   A sample accepted in cycle t is presented with o_vld high in cycle t+2.
//   While o_vld is high and i_rdy is low, both stages hold and no requester
//   is accepted.
//
// Configuration macro:
//   ROUND_ARB_SAT_EN - when defined, a round-up that overflows OUT_W
//                      saturates to +2^(OUT_W-1)-1. When undefined, the
//                      result wraps (two's complement).
//
// Ports:
//   mclk        in   1            clock, rising edge
//   i_init_n    in   1            synchronous active-low reset
//   i_req_vld   in   N_REQ        per-requester sample valid
//   i_req_data  in   N_REQ*IN_W   samples, requester k at [k*IN_W +: IN_W]
//   o_req_rdy   out  N_REQ        per-requester accept (one-hot or zero)
//   i_rdy       in   1            downstream ready
//   o_vld       out  1            rounded sample valid
//   o_data      out  OUT_W        rounded sample
//   o_id        out  ID_W         requester index that sourced o_data
// ---------------------------------------------------------------------------
module round_arb #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 18,
    parameter int OUT_W = 16,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    mclk,
    input  logic                    i_init_n,
    input  logic [N_REQ-1:0]        i_req_vld,
    input  logic [N_REQ*IN_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]        o_req_rdy,
    input  logic                    i_rdy,
    output logic                    o_vld,
    output logic [OUT_W-1:0]        o_data,
    output logic [ID_W-1:0]         o_id
);

    // Number of LSBs removed by the rounder.
    localparam int DROP_W = IN_W - OUT_W;
    // Requester count and last index in the width of the wrap arithmetic.
    localparam logic [ID_W:0]   N_REQ_L = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // Round-robin pick: scans offsets 0..N_REQ-1 starting at ptr and
    // returns {found, index} of the first valid requester, wrapping to 0.
    // ------------------------------------------------------------------
    function automatic logic [ID_W:0] rr_pick(
        input logic [N_REQ-1:0] vld,
        input logic [ID_W-1:0]  ptr
    );
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        logic            found;
        logic [ID_W-1:0] pick;
        found = 1'b0;
        pick  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (sum >= N_REQ_L) begin
                sum = sum - N_REQ_L;
            end else begin
                sum = sum;
            end
            cand = sum[ID_W-1:0];
            if (!found && vld[cand]) begin
                found = 1'b1;
                pick  = cand;
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    // ------------------------------------------------------------------
    // Convergent rounding: add 0 followed by (DROP_W-1) ones, plus the
    // lowest kept bit, then drop DROP_W LSBs. The sum is carried in
    // IN_W+1 bits so a round-up of the largest positive input is visible
    // as an overflow into the extra bit.
    // ------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] round_conv(input logic [IN_W-1:0] x);
        logic [IN_W:0]  ext;
        logic [IN_W:0]  bias;
        logic [IN_W:0]  sum;
        logic [OUT_W:0] kept;
        logic [OUT_W-1:0] res;
        ext  = {x[IN_W-1], x};
        bias = '0;
        for (int b = 0; b < DROP_W - 1; b++) begin
            bias[b] = 1'b1;
        end
        bias = bias + {{IN_W{1'b0}}, x[DROP_W]};
        sum  = ext + bias;
        kept = sum[IN_W:DROP_W];
`ifdef ROUND_ARB_SAT_EN
        // Rounding only moves values upward, so the sole overflow case is
        // positive: clamp to the largest representable value.
        if (kept[OUT_W] != kept[OUT_W-1]) begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            res = kept[OUT_W-1:0];
        end
`else
        res = kept[OUT_W-1:0];
`endif
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  ptr_r;
    logic             s1_vld_r;
    logic [IN_W-1:0]  s1_data_r;
    logic [ID_W-1:0]  s1_id_r;

    logic             stall_s;
    logic             grant_vld_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic             xfer_s;
    logic [IN_W-1:0]  grant_data_s;
    logic [IN_W-1:0]  req_sample_s [N_REQ];

    // Unpack the flat sample bus into one word per requester.
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_sample_s[k] = i_req_data[k*IN_W +: IN_W];
    end

    // Stall: an output is waiting and downstream is not taking it.
    always_comb begin
        stall_s = o_vld & ~i_rdy;
    end

    // Arbitration and accept generation; only valids, ptr, stall and reset
    // feed this path, never the sample data.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        o_req_rdy   = '0;
        {grant_vld_s, grant_idx_s} = rr_pick(i_req_vld, ptr_r);
        if (i_init_n && grant_vld_s && !stall_s) begin
            o_req_rdy[grant_idx_s] = 1'b1;
        end else begin
            o_req_rdy = '0;
        end
    end

    // A transfer happens when the granted requester sees its accept.
    always_comb begin
        xfer_s       = i_init_n & grant_vld_s & ~stall_s;
        grant_data_s = req_sample_s[grant_idx_s];
    end

    // Round-robin pointer: moves past the granted index on each transfer.
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            ptr_r <= '0;
        end else if (xfer_s) begin
            if (grant_idx_s == LAST_ID) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_idx_s + ID_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Stage 1: capture the granted sample and index; hold while stalled.
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            s1_vld_r  <= 1'b0;
            s1_data_r <= '0;
            s1_id_r   <= '0;
        end else if (!stall_s) begin
            s1_vld_r  <= xfer_s;
            s1_data_r <= grant_data_s;
            s1_id_r   <= grant_idx_s;
        end else begin
            s1_vld_r  <= s1_vld_r;
            s1_data_r <= s1_data_r;
            s1_id_r   <= s1_id_r;
        end
    end

    // Stage 2: register the rounded result; hold output stable while stalled.
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_id   <= '0;
        end else if (!stall_s) begin
            o_vld  <= s1_vld_r;
            o_data <= round_conv(s1_data_r);
            o_id   <= s1_id_r;
        end else begin
            o_vld  <= o_vld;
            o_data <= o_data;
            o_id   <= o_id;
        end
    end

endmodule
